// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1:16 11-bit write demux.
package demux_pkg;

    localparam int unsigned SLOT_W  = 11;
    localparam int unsigned N_SLOTS = 16;
    localparam int unsigned SEL_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/slot_reg_11b.sv
// One storage slot: register with write enable, synchronous clear and sync reset.
module slot_reg_11b #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear takes priority over write; the sweep never overlaps a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux_1_16_11b_reg.sv
// 1:16 registered write demux with valid/ready write port, per-slot valid and a 16-cycle clear sweep.
// Optional slot locking when DEMUX_LOCK_EN is defined (adds lock_set / wr_err).
module demux_1_16_11b_reg #(
    parameter int unsigned SLOT_W  = 11,
    parameter int unsigned N_SLOTS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SLOT_W-1:0]  DIN,
    input  logic               sel3,
    input  logic               sel2,
    input  logic               sel1,
    input  logic               sel0,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic               wr_ack,
    input  logic               clr_start,
    output logic               busy,
`ifdef DEMUX_LOCK_EN
    input  logic               lock_set,
    output logic               wr_err,
`endif
    output logic [SLOT_W-1:0]  A,
    output logic [SLOT_W-1:0]  B,
    output logic [SLOT_W-1:0]  C,
    output logic [SLOT_W-1:0]  D,
    output logic [SLOT_W-1:0]  E,
    output logic [SLOT_W-1:0]  F,
    output logic [SLOT_W-1:0]  G,
    output logic [SLOT_W-1:0]  H,
    output logic [SLOT_W-1:0]  I,
    output logic [SLOT_W-1:0]  J,
    output logic [SLOT_W-1:0]  K,
    output logic [SLOT_W-1:0]  L,
    output logic [SLOT_W-1:0]  M,
    output logic [SLOT_W-1:0]  N,
    output logic [SLOT_W-1:0]  O,
    output logic [SLOT_W-1:0]  P,
    output logic [N_SLOTS-1:0] VALID
);

    import demux_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   cnt;
    logic [SEL_W-1:0]   cnt_nxt;
    logic [SEL_W-1:0]   sel;
    logic               accept;
    logic               locked;
    logic               commit;
    logic [N_SLOTS-1:0] we;
    logic [N_SLOTS-1:0] clr;
    logic [SLOT_W-1:0]  slot_q [N_SLOTS];

`ifdef DEMUX_LOCK_EN
    logic [N_SLOTS-1:0] lock_q;
    assign locked = lock_q[sel];
`else
    assign locked = 1'b0;
`endif

    assign sel      = {sel3, sel2, sel1, sel0};
    assign wr_ready = (state == IDLE) && !clr_start;
    assign accept   = wr_valid && wr_ready;
    assign commit   = accept && !locked;

    // Next state, sweep counter and per-slot write/clear decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we        = '0;
        clr       = '0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (commit) begin
                    we[sel] = 1'b1;
                end
            end
            CLEAR: begin
                clr[cnt] = 1'b1;
                cnt_nxt  = SEL_W'(cnt + 1'b1);
                if (cnt == SEL_W'(N_SLOTS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            wr_ack <= 1'b0;
            VALID  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= (state_nxt == CLEAR);
            wr_ack <= commit;
            VALID  <= (VALID | we) & ~clr;
        end
    end

`ifdef DEMUX_LOCK_EN
    // Locks survive the clear sweep; only reset drops them.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= '0;
            wr_err <= 1'b0;
        end else begin
            lock_q <= lock_q | (lock_set ? we : '0);
            wr_err <= accept && locked;
        end
    end
`endif

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        slot_reg_11b #(.W(SLOT_W)) u_slot (
            .clk (clk),
            .rst (rst),
            .we  (we[i]),
            .clr (clr[i]),
            .d   (DIN),
            .q   (slot_q[i])
        );
    end

    assign A = slot_q[0];
    assign B = slot_q[1];
    assign C = slot_q[2];
    assign D = slot_q[3];
    assign E = slot_q[4];
    assign F = slot_q[5];
    assign G = slot_q[6];
    assign H = slot_q[7];
    assign I = slot_q[8];
    assign J = slot_q[9];
    assign K = slot_q[10];
    assign L = slot_q[11];
    assign M = slot_q[12];
    assign N = slot_q[13];
    assign O = slot_q[14];
    assign P = slot_q[15];

endmodule

// File: tb/tb_demux_1_16_11b_reg.sv
// Directed self-checking bench for demux_1_16_11b_reg (lock checks only when DEMUX_LOCK_EN is defined).
module tb_demux_1_16_11b_reg;

    logic        clk;
    logic        rst;
    logic [10:0] din;
    logic        sel3, sel2, sel1, sel0;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_ack;
    logic        clr_start;
    logic        busy;
`ifdef DEMUX_LOCK_EN
    logic        lock_set;
    logic        wr_err;
`endif
    logic [10:0] a, b, c, d, e, f, g, h, i_s, j, k, l, m, n, o, p;
    logic [15:0] valid;

    int n_cmp = 0;
    int n_err = 0;

    demux_1_16_11b_reg dut (
        .clk       (clk),
        .rst       (rst),
        .DIN       (din),
        .sel3      (sel3),
        .sel2      (sel2),
        .sel1      (sel1),
        .sel0      (sel0),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_ack    (wr_ack),
        .clr_start (clr_start),
        .busy      (busy),
`ifdef DEMUX_LOCK_EN
        .lock_set  (lock_set),
        .wr_err    (wr_err),
`endif
        .A (a), .B (b), .C (c), .D (d), .E (e), .F (f), .G (g), .H (h),
        .I (i_s), .J (j), .K (k), .L (l), .M (m), .N (n), .O (o), .P (p),
        .VALID     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int s);
        {sel3, sel2, sel1, sel0} = 4'(s);
    endtask

    function automatic logic [10:0] get_slot(input int s);
        case (s)
            0: return a;   1: return b;   2: return c;   3: return d;
            4: return e;   5: return f;   6: return g;   7: return h;
            8: return i_s; 9: return j;   10: return k;  11: return l;
            12: return m;  13: return n;  14: return o;  default: return p;
        endcase
    endfunction

    function automatic logic [10:0] or_slots();
        logic [10:0] acc = '0;
        for (int s = 0; s < 16; s++) acc |= get_slot(s);
        return acc;
    endfunction

    // Returns the number of cycles busy was observed high, bounded.
    task automatic wait_sweep(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    int bcnt;

    initial begin
        rst = 1'b1; din = '0; set_sel(0); wr_valid = 1'b0; clr_start = 1'b0;
`ifdef DEMUX_LOCK_EN
        lock_set = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", valid, 16'h0000);
        chk("rst_slots", or_slots(), 11'h000);
        chk("rst_ack", wr_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", wr_ready, 1'b1);

        // Single write to slot D
        din = 11'h5A5; set_sel(3); wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("w1_d", d, 11'h5A5);
        chk("w1_valid", valid, 16'h0008);
        chk("w1_ack", wr_ack, 1'b1);
        for (int s = 0; s < 16; s++)
            if (s != 3) chk($sformatf("w1_other%0d", s), get_slot(s), 11'h000);
        tick();
        chk("w1_ack_drop", wr_ack, 1'b0);

        // 16 back-to-back writes, slot n <- n*3
        for (int s = 0; s < 16; s++) begin
            set_sel(s); din = 11'(s * 3); wr_valid = 1'b1;
            tick();
            chk($sformatf("b2b_ack%0d", s), wr_ack, 1'b1);
        end
        wr_valid = 1'b0;
        chk("b2b_valid", valid, 16'hFFFF);
        chk("b2b_p", p, 11'h02D);
        for (int s = 0; s < 16; s++)
            chk($sformatf("b2b_slot%0d", s), get_slot(s), 11'(s * 3));
        tick();
        chk("b2b_ack_drop", wr_ack, 1'b0);

        // Clear and write in the same cycle: clear wins
        clr_start = 1'b1; wr_valid = 1'b1; set_sel(5); din = 11'h7FF;
        #1;
        chk("clr_ready_low", wr_ready, 1'b0);
        tick();
        clr_start = 1'b0;
        chk("clr_no_ack", wr_ack, 1'b0);
        chk("clr_f_kept", f, 11'h00F);
        bcnt = 0;
        while (busy && bcnt < 40) begin
            bcnt++;
            clr_start = (bcnt == 3);
            if (bcnt == 10) wr_valid = 1'b0;
            if (bcnt == 5) chk("clr_ready_busy", wr_ready, 1'b0);
            tick();
        end
        clr_start = 1'b0;
        chk("clr_busy_cycles", 32'(bcnt), 32'd16);
        chk("clr_slots", or_slots(), 11'h000);
        chk("clr_valid", valid, 16'h0000);
        chk("clr_ready_back", wr_ready, 1'b1);
        chk("clr_ack", wr_ack, 1'b0);

        // Reset at cycle 7 of a sweep
        set_sel(9); din = 11'h321; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("pre_j", j, 11'h321);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        chk("mid_busy", busy, 1'b1);
        chk("mid_j_intact", j, 11'h321);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_valid", valid, 16'h0000);
        chk("rstmid_ready", wr_ready, 1'b1);
        chk("rstmid_j", j, 11'h000);
        set_sel(9); din = 11'h321; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("post_j", j, 11'h321);
        chk("post_ack", wr_ack, 1'b1);
        chk("post_valid", valid, 16'h0200);

        // Reset coincident with a write: no ack, nothing stored
        set_sel(4); din = 11'h444; wr_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        chk("rstw_ack", wr_ack, 1'b0);
        chk("rstw_e", e, 11'h000);
        chk("rstw_valid", valid, 16'h0000);

`ifdef DEMUX_LOCK_EN
        // Locked slot rejects writes, survives a sweep
        set_sel(2); din = 11'h100; wr_valid = 1'b1; lock_set = 1'b1;
        tick();
        lock_set = 1'b0; din = 11'h0FF;
        chk("lk_first_ack", wr_ack, 1'b1);
        tick();
        wr_valid = 1'b0;
        chk("lk_c", c, 11'h100);
        chk("lk_err", wr_err, 1'b1);
        chk("lk_no_ack", wr_ack, 1'b0);
        tick();
        chk("lk_err_drop", wr_err, 1'b0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wait_sweep(bcnt);
        chk("lk_sweep_cycles", 32'(bcnt), 32'd16);
        chk("lk_c_cleared", c, 11'h000);
        set_sel(2); din = 11'h055; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("lk2_err", wr_err, 1'b1);
        chk("lk2_no_ack", wr_ack, 1'b0);
        chk("lk2_c", c, 11'h000);
        chk("lk2_valid", valid, 16'h0000);
`else
        wait_sweep(bcnt);
        chk("idle_no_busy", 32'(bcnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
